// File: rtl/reset_sequencer.sv
// Multi-source reset generator: a request edge restarts a held reset, then stages release in order.
// Optional macro RESET_SEQ_CAUSE_EN records which request bits caused the last restart.
module reset_sequencer #(
    parameter int unsigned NUM_SOURCES      = 2,
    parameter int unsigned NUM_STAGES       = 2,
    parameter int unsigned HOLD_CYCLES      = 128,
    parameter int unsigned STAGE_GAP_CYCLES = 16
) (
    input  logic                   clk_ext,
    input  logic                   reset,
    input  logic [NUM_SOURCES-1:0] req,
    output logic [NUM_STAGES-1:0]  rstn_stage,
    output logic                   busy,
    output logic [NUM_SOURCES-1:0] cause
);

    localparam int unsigned HOLD_W = $clog2((HOLD_CYCLES > 2) ? HOLD_CYCLES : 2);
    localparam int unsigned GAP_W  = $clog2((STAGE_GAP_CYCLES > 2) ? STAGE_GAP_CYCLES : 2);
    localparam int unsigned IDX_W  = $clog2((NUM_STAGES > 2) ? NUM_STAGES : 2);
    localparam int unsigned ST_W   = NUM_STAGES;

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(STAGE_GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_STAGES - 1);

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        IDLE    = 2'd2
    } state_t;

    state_t                 state, state_n;
    logic [HOLD_W-1:0]      hold_cnt, hold_cnt_n;
    logic [GAP_W-1:0]       gap_cnt, gap_cnt_n;
    logic [IDX_W-1:0]       stage_idx, stage_idx_n;
    logic [NUM_STAGES-1:0]  rstn_n;
    logic                   busy_n;
    logic [NUM_SOURCES-1:0] req_d;
    logic [NUM_SOURCES-1:0] trig;

    assign trig = req & ~req_d;

    always_ff @(posedge clk_ext or posedge reset) begin
        if (reset) begin
            state      <= HOLD;
            hold_cnt   <= HOLD_LOAD;
            gap_cnt    <= '0;
            stage_idx  <= '0;
            rstn_stage <= '0;
            busy       <= 1'b1;
            req_d      <= '0;
        end else begin
            state      <= state_n;
            hold_cnt   <= hold_cnt_n;
            gap_cnt    <= gap_cnt_n;
            stage_idx  <= stage_idx_n;
            rstn_stage <= rstn_n;
            busy       <= busy_n;
            req_d      <= req;
        end
    end

    // A trigger overrides every state, including a release due on the same edge.
    always_comb begin
        state_n     = state;
        hold_cnt_n  = hold_cnt;
        gap_cnt_n   = gap_cnt;
        stage_idx_n = stage_idx;
        rstn_n      = rstn_stage;
        busy_n      = busy;

        if (|trig) begin
            state_n     = HOLD;
            hold_cnt_n  = HOLD_LOAD;
            gap_cnt_n   = '0;
            stage_idx_n = '0;
            rstn_n      = '0;
            busy_n      = 1'b1;
        end else begin
            case (state)
                HOLD: begin
                    busy_n = 1'b1;
                    if (hold_cnt != '0) begin
                        hold_cnt_n = hold_cnt - HOLD_W'(1);
                    end else if (~|req) begin
                        rstn_n[0] = 1'b1;
                        if (NUM_STAGES == 1) begin
                            state_n = IDLE;
                            busy_n  = 1'b0;
                        end else begin
                            state_n     = RELEASE;
                            stage_idx_n = IDX_W'(1);
                            gap_cnt_n   = GAP_LOAD;
                        end
                    end
                end
                RELEASE: begin
                    busy_n = 1'b1;
                    if (gap_cnt != '0) begin
                        gap_cnt_n = gap_cnt - GAP_W'(1);
                    end else begin
                        rstn_n = rstn_stage | (ST_W'(1) << stage_idx);
                        if (stage_idx == LAST_IDX) begin
                            state_n = IDLE;
                            busy_n  = 1'b0;
                        end else begin
                            stage_idx_n = stage_idx + IDX_W'(1);
                            gap_cnt_n   = GAP_LOAD;
                        end
                    end
                end
                IDLE: begin
                    rstn_n = '1;
                    busy_n = 1'b0;
                end
                default: begin
                    state_n = HOLD;
                end
            endcase
        end
    end

`ifdef RESET_SEQ_CAUSE_EN
    // Cause survives the sequence so software can read why the last restart happened.
    always_ff @(posedge clk_ext or posedge reset) begin
        if (reset) begin
            cause <= '0;
        end else if (|trig) begin
            cause <= trig;
        end
    end
`else
    assign cause = '0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: a timing-based model checked every cycle plus literal edge checks.
module tb_reset_sequencer;

    localparam int NS   = 2;
    localparam int NST  = 2;
    localparam int HOLD = 128;
    localparam int GAP  = 16;

    logic           clk_ext = 1'b0;
    logic           reset;
    logic [NS-1:0]  req;
    logic [NST-1:0] rstn_stage;
    logic           busy;
    logic [NS-1:0]  cause;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // model: edge count, edge a hold started, edge stage 0 released (-1 while held)
    int            cyc        = 0;
    int            hold_start = 0;
    int            rel0       = -1;
    logic [NS-1:0] m_prev     = '0;
    logic [NS-1:0] m_cause    = '0;
    logic [NS-1:0] m_trig;

    reset_sequencer #(
        .NUM_SOURCES      (NS),
        .NUM_STAGES       (NST),
        .HOLD_CYCLES      (HOLD),
        .STAGE_GAP_CYCLES (GAP)
    ) dut (
        .clk_ext    (clk_ext),
        .reset      (reset),
        .req        (req),
        .rstn_stage (rstn_stage),
        .busy       (busy),
        .cause      (cause)
    );

    always #5 clk_ext = ~clk_ext;

    function automatic logic [NS-1:0] exp_cause(input logic [NS-1:0] v);
`ifdef RESET_SEQ_CAUSE_EN
        return v;
`else
        return '0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_ext);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [NST-1:0] r, input logic b);
        check({name, "_rstn"}, 32'(rstn_stage), 32'(r));
        check({name, "_busy"}, 32'(busy), 32'(b));
    endtask

    // Model: a hold of HOLD edges starting at the trigger/reset edge, then stage k at rel0 + k*GAP.
    always @(posedge clk_ext) begin
        cyc++;
        if (reset) begin
            hold_start = cyc;
            rel0       = -1;
            m_prev     = '0;
            m_cause    = '0;
        end else begin
            m_trig = req & ~m_prev;
            if (m_trig != '0) begin
                hold_start = cyc;
                rel0       = -1;
                m_cause    = m_trig;
            end else if (rel0 < 0 && cyc >= hold_start + HOLD && req == '0) begin
                rel0 = cyc;
            end
            m_prev = req;
        end
    end

    always @(negedge clk_ext) begin
        logic [NST-1:0] er;
        logic           eb;
        logic [NS-1:0]  ec;
        if (reset) begin
            er = '0;
            eb = 1'b1;
            ec = '0;
        end else begin
            for (int k = 0; k < NST; k++)
                er[k] = (rel0 >= 0) && (cyc >= rel0 + k * GAP);
            eb = (er != '1);
            ec = exp_cause(m_cause);
        end
        check("model_rstn", 32'(rstn_stage), 32'(er));
        check("model_busy", 32'(busy), 32'(eb));
        check("model_cause", 32'(cause), 32'(ec));
    end

    initial begin
        reset = 1'b1;
        req   = '0;

        // power-up sequence
        step(3);
        expect_out("por_reset", 2'b00, 1'b1);
        check("por_cause", 32'(cause), 32'h0);
        reset = 1'b0;
        step(127);
        expect_out("por_e127", 2'b00, 1'b1);
        step(1);
        expect_out("por_e128", 2'b01, 1'b1);
        step(15);
        expect_out("por_e143", 2'b01, 1'b1);
        step(1);
        expect_out("por_e144", 2'b11, 1'b0);

        // single-cycle pulse on req[1]
        step(5);
        req = 2'b10;
        step(1);
        req = 2'b00;
        expect_out("pulse_t1", 2'b00, 1'b1);
        check("pulse_cause", 32'(cause), 32'(exp_cause(2'b10)));
        step(127);
        expect_out("pulse_t128", 2'b00, 1'b1);
        step(1);
        expect_out("pulse_t129", 2'b01, 1'b1);
        step(15);
        expect_out("pulse_t144", 2'b01, 1'b1);
        step(1);
        expect_out("pulse_t145", 2'b11, 1'b0);

        // held request extends the hold
        step(3);
        req = 2'b01;
        step(300);
        expect_out("held_t300", 2'b00, 1'b1);
        req = 2'b00;
        step(1);
        expect_out("held_t301", 2'b01, 1'b1);
        step(16);
        expect_out("held_t317", 2'b11, 1'b0);

        // re-trigger during RELEASE
        step(2);
        req = 2'b01;
        step(1);
        req = 2'b00;
        step(128);
        expect_out("retrig_rel0", 2'b01, 1'b1);
        step(4);
        req = 2'b01;
        step(1);
        req = 2'b00;
        expect_out("retrig_assert", 2'b00, 1'b1);
        step(127);
        expect_out("retrig_e127", 2'b00, 1'b1);
        step(1);
        expect_out("retrig_e128", 2'b01, 1'b1);
        step(16);
        expect_out("retrig_e144", 2'b11, 1'b0);

        // dual trigger exactly when hold_cnt reaches zero
        step(2);
        req = 2'b01;
        step(1);
        req = 2'b00;
        step(126);
        req = 2'b11;
        step(1);
        req = 2'b00;
        expect_out("dual_norel", 2'b00, 1'b1);
        check("dual_cause", 32'(cause), 32'(exp_cause(2'b11)));
        step(127);
        expect_out("dual_e127", 2'b00, 1'b1);
        step(1);
        expect_out("dual_e128", 2'b01, 1'b1);
        step(16);
        expect_out("dual_e144", 2'b11, 1'b0);

        // asynchronous reset in RELEASE
        step(2);
        req = 2'b10;
        step(1);
        req = 2'b00;
        step(131);
        expect_out("arst_pre", 2'b01, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        expect_out("arst_now", 2'b00, 1'b1);
        check("arst_cause", 32'(cause), 32'h0);
        step(2);
        reset = 1'b0;
        step(127);
        expect_out("arst_e127", 2'b00, 1'b1);
        step(1);
        expect_out("arst_e128", 2'b01, 1'b1);
        step(16);
        expect_out("arst_e144", 2'b11, 1'b0);
        check("arst_cause_end", 32'(cause), 32'h0);

        step(3);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
